// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divider constants and the
// baud-select decode used by both ends of a link.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned OSR_DEFAULT = 16;
  localparam int unsigned DIV_W       = 9;

  // Clocks per oversampling tick minus one, from the 50 MHz system clock.
  localparam logic [DIV_W-1:0] DIV_9600   = 9'd324;
  localparam logic [DIV_W-1:0] DIV_19200  = 9'd161;
  localparam logic [DIV_W-1:0] DIV_38400  = 9'd80;
  localparam logic [DIV_W-1:0] DIV_57600  = 9'd53;
  localparam logic [DIV_W-1:0] DIV_115200 = 9'd26;

  function automatic logic [DIV_W-1:0] baudReload(input logic [3:0] baudSel);
    logic [DIV_W-1:0] reload;
    case (baudSel)
      4'd1:    reload = DIV_9600;
      4'd2:    reload = DIV_19200;
      4'd3:    reload = DIV_38400;
      4'd4:    reload = DIV_57600;
      default: reload = DIV_115200;
    endcase
    return reload;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Down-counting tick divider: one-cycle tick every load_i+1 clocks while enabled,
// parked at the load value while disabled.
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] load_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!en_i || (count_q == '0)) begin
      count_d = load_i;
    end else begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = en_i && (count_q == '0);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start/busy handshake, LSB-first serialisation on OSR
// ticks per bit, one-cycle done pulse when the stop bit ends.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned OSR        = OSR_DEFAULT,
  parameter int unsigned STOP_TICKS = 16
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic [3:0] baud_set_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start_i,
  output logic       uart_tx_o,
  output logic       tx_busy_o,
  output logic       tx_done_o
);

  localparam int unsigned MAX_TICKS = (STOP_TICKS > OSR) ? STOP_TICKS : OSR;
  localparam int unsigned CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CNT_W-1:0] OSR_LAST  = CNT_W'(OSR - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_TICKS - 1);

  uart_state_e      state_q;
  logic [DIV_W-1:0] divider_q;
  logic [DIV_W-1:0] reloadSel;
  logic [7:0]       shift_q;
  logic [2:0]       bitIdx_q;
  logic [CNT_W-1:0] tickCnt_q;
  logic             txLine_q;
  logic             busy_q;
  logic             done_q;
  logic             tick;
  logic             accept;

  assign accept = tx_start_i && !busy_q;

  // While idle the divider tracks the live baud select so the count is already
  // at the right reload value on the accept edge.
  assign reloadSel = (state_q == IDLE) ? baudReload(baud_set_i) : divider_q;

  uart_baud_tick u_baud_tick (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .en_i   (state_q != IDLE),
    .load_i (reloadSel),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      divider_q <= '0;
      shift_q   <= '0;
      bitIdx_q  <= '0;
      tickCnt_q <= '0;
      txLine_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q   <= tx_data_i;
            divider_q <= baudReload(baud_set_i);
            bitIdx_q  <= '0;
            tickCnt_q <= '0;
            txLine_q  <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tickCnt_q == OSR_LAST) begin
              tickCnt_q <= '0;
              bitIdx_q  <= '0;
              txLine_q  <= shift_q[0];
              state_q   <= DATA;
            end else begin
              tickCnt_q <= tickCnt_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tickCnt_q == OSR_LAST) begin
              tickCnt_q <= '0;
              if (bitIdx_q == 3'd7) begin
                txLine_q <= 1'b1;
                state_q  <= STOP;
              end else begin
                shift_q  <= {1'b0, shift_q[7:1]};
                txLine_q <= shift_q[1];
                bitIdx_q <= bitIdx_q + 1'b1;
              end
            end else begin
              tickCnt_q <= tickCnt_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tickCnt_q == STOP_LAST) begin
              tickCnt_q <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= IDLE;
            end else begin
              tickCnt_q <= tickCnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_tx_o = txLine_q;
  assign tx_busy_o = busy_q;
  assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line monitor
// decodes each frame cycle by cycle and checks shape, byte, busy and done timing.
module tb_uart_tx;

  logic       clk_i = 1'b0;
  logic       rst_n;
  logic [3:0] baud_set_i;
  logic [7:0] tx_data_i;
  logic       tx_start_i;
  logic       uart_tx_o;
  logic       tx_busy_o;
  logic       tx_done_o;

  always #5 clk_i = ~clk_i;

  uart_tx #(.OSR(16), .STOP_TICKS(16)) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .baud_set_i (baud_set_i),
    .tx_data_i  (tx_data_i),
    .tx_start_i (tx_start_i),
    .uart_tx_o  (uart_tx_o),
    .tx_busy_o  (tx_busy_o),
    .tx_done_o  (tx_done_o)
  );

  typedef struct {
    logic [7:0] data;
    int         period;
    bit         abort;
  } frameExp_t;

  frameExp_t expQ[$];
  int checks         = 0;
  int errors         = 0;
  int spuriousDone   = 0;
  int framesSeen     = 0;
  int framesExpected = 0;
  bit inFrame        = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  function automatic int periodFor(input logic [3:0] sel);
    case (sel)
      4'd1:    return 5200;
      4'd2:    return 2592;
      4'd3:    return 1296;
      4'd4:    return 864;
      default: return 432;
    endcase
  endfunction

  task automatic pushExp(input logic [7:0] data, input logic [3:0] sel, input bit abort);
    frameExp_t e;
    e.data   = data;
    e.period = periodFor(sel);
    e.abort  = abort;
    expQ.push_back(e);
    framesExpected++;
  endtask

  // Called at a negedge; returns at the negedge of the first low (start) cycle.
  task automatic applyStimulus(input logic [7:0] data, input logic [3:0] sel, input bit abort);
    int guard = 0;
    while (tx_busy_o !== 1'b0 && guard < 60000) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 60000) checkOutput("startWaitTimeout", 32'd1, 32'd0);
    tx_data_i  = data;
    baud_set_i = sel;
    tx_start_i = 1'b1;
    pushExp(data, sel, abort);
    @(negedge clk_i);
    tx_start_i = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int guard = 0;
    while ((expQ.size() != 0 || inFrame) && guard < maxCycles) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= maxCycles) checkOutput("drainTimeout", 32'd1, 32'd0);
  endtask

  task automatic runFrame(input frameExp_t e);
    logic [9:0] bitsExp;
    logic [7:0] rxByte;
    int lineErr   = 0;
    int busyErr   = 0;
    int doneEarly = 0;
    int idx;
    bit aborted   = 1'b0;
    bitsExp = {1'b1, e.data, 1'b0};
    rxByte  = '0;
    for (int n = 0; n < 10 * e.period; n++) begin
      if (n > 0) @(negedge clk_i);
      if (rst_n !== 1'b1) begin
        aborted = 1'b1;
        break;
      end
      idx = n / e.period;
      if (uart_tx_o !== bitsExp[4'(idx)]) lineErr++;
      if (tx_busy_o !== 1'b1) busyErr++;
      if (tx_done_o !== 1'b0) doneEarly++;
      if ((n % e.period) == (e.period / 2) && idx >= 1 && idx <= 8) rxByte[3'(idx - 1)] = uart_tx_o;
    end
    if (aborted) begin
      if (!e.abort) checkOutput("unexpectedReset", 32'd1, 32'd0);
      checkOutput("abortLineBeforeReset", lineErr, 32'd0);
      checkOutput("abortNoDone", doneEarly, 32'd0);
      return;
    end
    @(negedge clk_i);
    if (e.abort) checkOutput("abortedFrameCompleted", 32'd1, 32'd0);
    checkOutput($sformatf("lineShape_%02h", e.data), lineErr, 32'd0);
    checkOutput($sformatf("busyHigh_%02h", e.data), busyErr, 32'd0);
    checkOutput($sformatf("doneEarly_%02h", e.data), doneEarly, 32'd0);
    checkOutput($sformatf("rxByte_%02h", e.data), {24'd0, rxByte}, {24'd0, e.data});
    checkOutput($sformatf("doneAtEnd_%02h", e.data), {31'd0, tx_done_o}, 32'd1);
    checkOutput($sformatf("busyAtEnd_%02h", e.data), {31'd0, tx_busy_o}, 32'd0);
  endtask

  initial begin : monitor
    frameExp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_n === 1'b1 && uart_tx_o === 1'b0) begin
        framesSeen++;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedFrame", 32'd1, 32'd0);
          for (int g = 0; g < 60000; g++) begin
            @(negedge clk_i);
            if (tx_done_o === 1'b1 || rst_n !== 1'b1) break;
          end
        end else begin
          e       = expQ.pop_front();
          inFrame = 1'b1;
          runFrame(e);
          inFrame = 1'b0;
        end
      end else if (tx_done_o === 1'b1) begin
        spuriousDone++;
      end
    end
  end

  initial begin : stimulus
    int guard;
    rst_n      = 1'b0;
    tx_start_i = 1'b0;
    tx_data_i  = 8'h00;
    baud_set_i = 4'd5;
    repeat (3) @(negedge clk_i);
    checkOutput("resetLine", {31'd0, uart_tx_o}, 32'd1);
    checkOutput("resetBusy", {31'd0, tx_busy_o}, 32'd0);
    checkOutput("resetDone", {31'd0, tx_done_o}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_i);

    // 0xA5 at 115200; baud and data changes mid-frame must not matter
    applyStimulus(8'hA5, 4'd5, 1'b0);
    baud_set_i = 4'd1;
    tx_data_i  = 8'h00;
    waitDrain(6000);

    applyStimulus(8'h00, 4'd1, 1'b0);
    waitDrain(60000);

    // back-to-back 0x12 (baud_set 0) then 0x34 (baud_set 15), start held high
    tx_data_i  = 8'h12;
    baud_set_i = 4'd0;
    tx_start_i = 1'b1;
    pushExp(8'h12, 4'd0, 1'b0);
    @(negedge clk_i);
    tx_data_i  = 8'h34;
    baud_set_i = 4'd15;
    pushExp(8'h34, 4'd15, 1'b0);
    guard = 0;
    while (tx_done_o !== 1'b1 && guard < 6000) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 6000) checkOutput("backToBackDoneTimeout", 32'd1, 32'd0);
    @(negedge clk_i);
    tx_start_i = 1'b0;
    checkOutput("backToBackNoGapLine", {31'd0, uart_tx_o}, 32'd0);
    checkOutput("backToBackNoGapBusy", {31'd0, tx_busy_o}, 32'd1);
    waitDrain(6000);

    // start pulses while busy are dropped
    applyStimulus(8'h55, 4'd5, 1'b0);
    repeat (1000) @(negedge clk_i);
    tx_data_i  = 8'hFF;
    tx_start_i = 1'b1;
    repeat (3) @(negedge clk_i);
    tx_start_i = 1'b0;
    waitDrain(6000);
    repeat (500) @(negedge clk_i);
    checkOutput("ignoredStartFrames", framesSeen, framesExpected);

    // reset in the middle of data bit 3
    applyStimulus(8'hC3, 4'd5, 1'b1);
    repeat (4 * 432 + 216) @(negedge clk_i);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midResetLine", {31'd0, uart_tx_o}, 32'd1);
    checkOutput("midResetBusy", {31'd0, tx_busy_o}, 32'd0);
    checkOutput("midResetDone", {31'd0, tx_done_o}, 32'd0);
    repeat (4) @(negedge clk_i);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_i);
    waitDrain(100);

    applyStimulus(8'h3C, 4'd4, 1'b0);
    waitDrain(10000);

    repeat (200) @(negedge clk_i);
    checkOutput("spuriousDone", spuriousDone, 32'd0);
    checkOutput("frameCount", framesSeen, framesExpected);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
